// File: rtl/chaos_keystream_gen.sv
// chaos_keystream_gen: two-channel logistic/tent map keystream generator with one shared shift-add multiplier
module chaos_keystream_gen #(
  parameter int W = 16,
  parameter int CNT_W = 16,
  parameter logic [W-1:0] PERTURB = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [W-1:0]     seed_a,
  input  logic [W-1:0]     seed_b,
  input  logic [W-1:0]     coef_a,
  input  logic [W-1:0]     coef_b,
  input  logic             mode_a,
  input  logic             mode_b,
  input  logic             run,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     key_out,
  output logic [W-1:0]     x_a,
  output logic [W-1:0]     x_b,
  output logic [CNT_W-1:0] word_count,
  output logic             busy
);
  localparam int AW = 2*W+1;
  localparam int CW = $clog2(W)+1;
  typedef enum logic [2:0] {S_IDLE, S_M1, S_M2, S_UPD, S_OUT} state_t;
  state_t state_q, state_d;
  logic ch_q, ch_d;
  logic [W-1:0] x_a_q, x_b_q, coef_a_q, coef_b_q, key_q, mp_q;
  logic mode_a_q, mode_b_q, out_valid_q;
  logic [CNT_W-1:0] words_q;
  logic [AW-1:0] mc_q, acc_q, acc_nxt, nsh;
  logic [CW-1:0] step_q;
  logic [W-1:0] x_cur, coef_cur, x_ent, coef_ent, tent_m, n_sat, n_new;
  logic [W:0] inv_x;
  logic mode_cur, mode_ent, done, hs, ent_m1, ent_m2;
  assign x_cur = ch_q ? x_b_q : x_a_q;
  assign coef_cur = ch_q ? coef_b_q : coef_a_q;
  assign mode_cur = ch_q ? mode_b_q : mode_a_q;
  assign x_ent = ch_d ? x_b_q : x_a_q;
  assign coef_ent = ch_d ? coef_b_q : coef_a_q;
  assign mode_ent = ch_d ? mode_b_q : mode_a_q;
  assign inv_x = {1'b1, {W{1'b0}}} - {1'b0, x_ent};
  assign tent_m = (x_ent < ~x_ent) ? x_ent : ~x_ent;
  assign done = step_q == CW'(W-1);
  assign hs = out_valid_q && out_ready;
  assign acc_nxt = acc_q + (mp_q[0] ? mc_q : '0);
  assign ent_m1 = state_d == S_M1 && state_q != S_M1;
  assign ent_m2 = state_d == S_M2 && state_q == S_M1;
  assign nsh = acc_q >> (W-2);
  assign n_sat = |(nsh >> W) ? '1 : nsh[W-1:0];
  assign n_new = (n_sat == '0 || n_sat == x_cur) ? n_sat ^ PERTURB : n_sat;
  assign out_valid = out_valid_q;
  assign key_out = key_q;
  assign x_a = x_a_q;
  assign x_b = x_b_q;
  assign word_count = words_q;
  assign busy = state_q != S_IDLE && state_q != S_OUT;
  // Next-state logic; load overrides everything and parks the sequencer in S_IDLE
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    case (state_q)
      S_IDLE: if (run) begin state_d = S_M1; ch_d = 1'b0; end
      S_M1: if (done) state_d = mode_cur ? S_UPD : S_M2;
      S_M2: if (done) state_d = S_UPD;
      S_UPD: begin state_d = ch_q ? S_OUT : S_M1; ch_d = 1'b1; end
      S_OUT: if (hs) begin state_d = run ? S_M1 : S_IDLE; ch_d = 1'b0; end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d = S_IDLE;
      ch_d = 1'b0;
    end
  end
  // State register and channel pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
    end
  end
  // Configuration capture and channel state write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_a_q <= '0;
      x_b_q <= '0;
      coef_a_q <= '0;
      coef_b_q <= '0;
      mode_a_q <= 1'b0;
      mode_b_q <= 1'b0;
    end else if (load) begin
      x_a_q <= seed_a;
      x_b_q <= seed_b;
      coef_a_q <= coef_a;
      coef_b_q <= coef_b;
      mode_a_q <= mode_a;
      mode_b_q <= mode_b;
    end else if (state_q == S_UPD) begin
      if (ch_q) x_b_q <= n_new;
      else x_a_q <= n_new;
    end
  end
  // Radix-2 shift-add multiplier: operands loaded on entry to S_M1/S_M2, one multiplier bit per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mc_q <= '0;
      mp_q <= '0;
      acc_q <= '0;
      step_q <= '0;
    end else if (ent_m1) begin
      mc_q <= mode_ent ? AW'(tent_m) : AW'(inv_x);
      mp_q <= mode_ent ? coef_ent : x_ent;
      acc_q <= '0;
      step_q <= '0;
    end else if (ent_m2) begin
      mc_q <= acc_nxt >> W;
      mp_q <= coef_cur;
      acc_q <= '0;
      step_q <= '0;
    end else if (state_q == S_M1 || state_q == S_M2) begin
      mc_q <= mc_q << 1;
      mp_q <= mp_q >> 1;
      acc_q <= acc_nxt;
      step_q <= step_q + 1'b1;
    end
  end
  // Output word register, handshake and accepted-word counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      key_q <= '0;
      words_q <= '0;
    end else if (load) begin
      out_valid_q <= 1'b0;
    end else if (state_q == S_UPD && ch_q) begin
      out_valid_q <= 1'b1;
      key_q <= x_a_q ^ n_new;
    end else if (hs) begin
      out_valid_q <= 1'b0;
      words_q <= words_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_chaos_keystream_gen.sv
// tb_chaos_keystream_gen: directed and randomized checks of the chaotic keystream generator against an arithmetic model
module tb_chaos_keystream_gen;
  logic clk = 1'b0;
  logic reset, load, run, out_ready, mode_a, mode_b, out_valid, busy;
  logic [15:0] seed_a, seed_b, coef_a, coef_b, key_out, x_a, x_b, word_count;
  int total = 0;
  int bad = 0;
  logic [15:0] exp_wc = 16'h0;

  chaos_keystream_gen #(.W(16), .CNT_W(16), .PERTURB(16'h0001)) dut (
    .clk(clk), .reset(reset), .load(load), .seed_a(seed_a), .seed_b(seed_b),
    .coef_a(coef_a), .coef_b(coef_b), .mode_a(mode_a), .mode_b(mode_b),
    .run(run), .out_ready(out_ready), .out_valid(out_valid), .key_out(key_out),
    .x_a(x_a), .x_b(x_b), .word_count(word_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] c, input logic md);
    longint xi, ci, m, p, n;
    xi = longint'(x);
    ci = longint'(c);
    m = (xi < 65535 - xi) ? xi : 65535 - xi;
    p = (xi * (65536 - xi)) / 65536;
    n = md ? (ci * m) / 16384 : (ci * p) / 16384;
    if (n > 65535) n = 65535;
    if (n == 0 || n == xi) n = n ^ 1;
    return n[15:0];
  endfunction

  function automatic int lat_of(input logic ma, input logic mb);
    return 1 + (ma ? 17 : 33) + (mb ? 17 : 33);
  endfunction

  task automatic load_cfg(input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] ca,
                          input logic [15:0] cb, input logic ma, input logic mb);
    @(negedge clk);
    seed_a = sa; seed_b = sb; coef_a = ca; coef_b = cb; mode_a = ma; mode_b = mb;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic handshake(input logic rn);
    run = rn;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_wc = exp_wc + 16'h1;
  endtask

  task automatic test_reset;
    logic [15:0] got [6];
    string nm [6];
    got = '{16'(out_valid), key_out, x_a, x_b, word_count, 16'(busy)};
    nm = '{"rst_valid", "rst_key", "rst_xa", "rst_xb", "rst_wc", "rst_busy"};
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got[i] !== 16'h0) begin bad++; $display("FAIL %s got=%h want=0000", nm[i], got[i]); end
    end
  endtask

  task automatic test_maps;
    logic [15:0] sa [4] = '{16'h8000, 16'h8000, 16'h8000, 16'h0000};
    logic [15:0] ca [4] = '{16'hF000, 16'h8000, 16'hFFFF, 16'hF000};
    logic [15:0] cb [4] = '{16'hF000, 16'hF000, 16'hF000, 16'h8000};
    logic        ma [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] ea [4] = '{16'hF000, 16'hFFFE, 16'hFFFF, 16'h0001};
    logic [15:0] eb [4] = '{16'hF000, 16'hF000, 16'hF000, 16'h8001};
    int el [4] = '{67, 51, 51, 67};
    int n;
    for (int i = 0; i < 4; i++) begin
      load_cfg(sa[i], 16'h8000, ca[i], cb[i], ma[i], 1'b0);
      run = 1'b1;
      wait_valid(n);
      total++;
      if (n != el[i]) begin bad++; $display("FAIL map%0d_latency got=%0d want=%0d", i, n, el[i]); end
      total++;
      if (x_a !== ea[i]) begin bad++; $display("FAIL map%0d_xa got=%h want=%h", i, x_a, ea[i]); end
      total++;
      if (x_b !== eb[i]) begin bad++; $display("FAIL map%0d_xb got=%h want=%h", i, x_b, eb[i]); end
      total++;
      if (key_out !== (ea[i] ^ eb[i])) begin bad++; $display("FAIL map%0d_key got=%h want=%h", i, key_out, ea[i] ^ eb[i]); end
      handshake(1'b0);
      total++;
      if (word_count !== exp_wc) begin bad++; $display("FAIL map%0d_wc got=%h want=%h", i, word_count, exp_wc); end
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL map%0d_idle got=%b%b want=00", i, out_valid, busy); end
    end
  endtask

  task automatic test_random;
    logic [15:0] sa, sb, ca, cb, ea, eb;
    logic ma, mb;
    int n;
    for (int i = 0; i < 6; i++) begin
      sa = 16'($urandom); sb = 16'($urandom); ca = 16'($urandom); cb = 16'($urandom);
      ma = 1'($urandom); mb = 1'($urandom);
      ea = model(sa, ca, ma);
      eb = model(sb, cb, mb);
      load_cfg(sa, sb, ca, cb, ma, mb);
      run = 1'b1;
      wait_valid(n);
      total++;
      if (n != lat_of(ma, mb)) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, n, lat_of(ma, mb)); end
      total++;
      if (x_a !== ea || x_b !== eb) begin bad++; $display("FAIL rnd%0d_state got=%h/%h want=%h/%h", i, x_a, x_b, ea, eb); end
      total++;
      if (key_out !== (ea ^ eb)) begin bad++; $display("FAIL rnd%0d_key got=%h want=%h", i, key_out, ea ^ eb); end
      handshake(1'b0);
      total++;
      if (word_count !== exp_wc) begin bad++; $display("FAIL rnd%0d_wc got=%h want=%h", i, word_count, exp_wc); end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] k0, ea;
    logic stable;
    int n;
    load_cfg(16'h8000, 16'h8000, 16'hF000, 16'hF000, 1'b0, 1'b0);
    run = 1'b1;
    out_ready = 1'b0;
    wait_valid(n);
    k0 = key_out;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (key_out !== k0 || out_valid !== 1'b1 || busy !== 1'b0 || x_a !== 16'hF000) stable = 1'b0;
    end
    total++;
    if (!stable) begin bad++; $display("FAIL bp_hold got=%h/%b/%b want=%h/1/0", key_out, out_valid, busy, k0); end
    handshake(1'b1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b want=0", out_valid); end
    total++;
    if (word_count !== exp_wc) begin bad++; $display("FAIL bp_wc got=%h want=%h", word_count, exp_wc); end
    wait_valid(n);
    total++;
    if (n != 66) begin bad++; $display("FAIL bp_next_latency got=%0d want=66", n); end
    ea = model(16'hF000, 16'hF000, 1'b0);
    total++;
    if (x_a !== ea || key_out !== 16'h0000) begin bad++; $display("FAIL bp_second got=%h/%h want=%h/0000", x_a, key_out, ea); end
    handshake(1'b0);
  endtask

  task automatic test_load_abort;
    logic [15:0] ea, eb;
    int n;
    load_cfg(16'h8000, 16'h8000, 16'hF000, 16'hF000, 1'b0, 1'b0);
    run = 1'b1;
    repeat (20) @(posedge clk);
    load_cfg(16'h1234, 16'hC000, 16'h6000, 16'h7000, 1'b1, 1'b1);
    total++;
    if (x_a !== 16'h1234 || x_b !== 16'hC000) begin bad++; $display("FAIL abort_seed got=%h/%h want=1234/c000", x_a, x_b); end
    ea = model(16'h1234, 16'h6000, 1'b1);
    eb = model(16'hC000, 16'h7000, 1'b1);
    wait_valid(n);
    total++;
    if (n != 35) begin bad++; $display("FAIL abort_latency got=%0d want=35", n); end
    total++;
    if (key_out !== (ea ^ eb)) begin bad++; $display("FAIL abort_key got=%h want=%h", key_out, ea ^ eb); end
    handshake(1'b0);
    total++;
    if (word_count !== exp_wc) begin bad++; $display("FAIL abort_wc got=%h want=%h", word_count, exp_wc); end
  endtask

  task automatic test_reset_mid;
    load_cfg(16'h8000, 16'h4000, 16'hF000, 16'hF000, 1'b0, 1'b0);
    run = 1'b1;
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || key_out !== 16'h0) begin bad++; $display("FAIL mid_rst_ctl got=%b/%b/%h want=0/0/0000", out_valid, busy, key_out); end
    total++;
    if (x_a !== 16'h0 || x_b !== 16'h0 || word_count !== 16'h0) begin bad++; $display("FAIL mid_rst_state got=%h/%h/%h want=0/0/0", x_a, x_b, word_count); end
    exp_wc = 16'h0;
    @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_quiet got=%b/%b want=0/0", out_valid, busy); end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; run = 1'b0; out_ready = 1'b0;
    seed_a = '0; seed_b = '0; coef_a = '0; coef_b = '0; mode_a = 1'b0; mode_b = 1'b0;
    #12;
    test_reset;
    @(negedge clk);
    reset = 1'b0;
    test_maps;
    test_random;
    test_backpressure;
    test_load_abort;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
